// File: rtl/metric_tracker.sv
// Two-stage leading-match metric pipeline with running best result and saturating hit counter.
// Stage 1 counts leading zeros per slice of hash^target; stage 2 merges the slices and updates best/hits.

module metric_tracker_lzc #(
    parameter int CHUNK = 32,
    parameter int CW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] slice_i,
    output logic [CW-1:0]    cnt_o,
    output logic             zero_o
);
    logic found;

    always_comb begin
        cnt_o = CW'(CHUNK);
        found = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!found && slice_i[i]) begin
                cnt_o = CW'(CHUNK - 1 - i);
                found = 1'b1;
            end
        end
        zero_o = ~|slice_i;
    end
endmodule

module metric_tracker #(
    parameter int  WIDTH = 160,
    parameter int  CHUNK = 32,
    parameter int  TAG_W = 64,
    parameter int  CNT_W = 32,
    localparam int MW    = $clog2(WIDTH + 1) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic [MW-1:0]    threshold_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] hash_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             clear_i,
    output logic             out_valid_o,
    output logic [MW-1:0]    metric_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             hit_o,
    output logic             best_valid_o,
    output logic [MW-1:0]    best_metric_o,
    output logic [TAG_W-1:0] best_tag_o,
    output logic [CNT_W-1:0] hit_count_o
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(CHUNK + 1);

    logic [WIDTH-1:0]        diff;
    logic [NCH-1:0][CW-1:0]  s1_cnt_d, s1_cnt_q;
    logic [NCH-1:0]          s1_zero_d, s1_zero_q;
    logic                    s1_valid_d, s1_valid_q;
    logic [TAG_W-1:0]        s1_tag_d, s1_tag_q;

    logic                    out_valid_d, out_valid_q;
    logic [MW-1:0]           metric_d, metric_q;
    logic [TAG_W-1:0]        tag_d, tag_q;
    logic                    hit_d, hit_q;
    logic                    best_valid_d, best_valid_q;
    logic [MW-1:0]           best_metric_d, best_metric_q;
    logic [TAG_W-1:0]        best_tag_d, best_tag_q;
    logic [CNT_W-1:0]        hit_count_d, hit_count_q;
    logic                    found;

    assign diff = hash_i ^ target_i;

    // Slice g = 0 is the most significant CHUNK bits.
    for (genvar g = 0; g < NCH; g++) begin : g_slice
        metric_tracker_lzc #(.CHUNK(CHUNK), .CW(CW)) u_lzc (
            .slice_i (diff[WIDTH-1-g*CHUNK -: CHUNK]),
            .cnt_o   (s1_cnt_d[g]),
            .zero_o  (s1_zero_d[g])
        );
    end

    always_comb begin
        s1_valid_d = in_valid_i;
        s1_tag_d   = tag_i;
    end

    always_comb begin
        metric_d = MW'(WIDTH);
        found    = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && !s1_zero_q[k]) begin
                metric_d = MW'(k * CHUNK) + MW'(s1_cnt_q[k]);
                found    = 1'b1;
            end
        end
        hit_d       = (metric_d >= threshold_i);
        out_valid_d = s1_valid_q;
        tag_d       = s1_tag_q;
    end

    // Clear wins over a completing candidate; ties keep the earlier tag.
    always_comb begin
        best_valid_d  = best_valid_q;
        best_metric_d = best_metric_q;
        best_tag_d    = best_tag_q;
        hit_count_d   = hit_count_q;
        if (clear_i) begin
            best_valid_d  = 1'b0;
            best_metric_d = '0;
            best_tag_d    = '0;
            hit_count_d   = '0;
        end else if (s1_valid_q) begin
            if (!best_valid_q || metric_d > best_metric_q) begin
                best_valid_d  = 1'b1;
                best_metric_d = metric_d;
                best_tag_d    = s1_tag_q;
            end
            if (hit_d && hit_count_q != '1)
                hit_count_d = hit_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q    <= 1'b0;
            s1_cnt_q      <= '0;
            s1_zero_q     <= '0;
            s1_tag_q      <= '0;
            out_valid_q   <= 1'b0;
            metric_q      <= '0;
            tag_q         <= '0;
            hit_q         <= 1'b0;
            best_valid_q  <= 1'b0;
            best_metric_q <= '0;
            best_tag_q    <= '0;
            hit_count_q   <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_cnt_q      <= s1_cnt_d;
            s1_zero_q     <= s1_zero_d;
            s1_tag_q      <= s1_tag_d;
            out_valid_q   <= out_valid_d;
            metric_q      <= metric_d;
            tag_q         <= tag_d;
            hit_q         <= hit_d;
            best_valid_q  <= best_valid_d;
            best_metric_q <= best_metric_d;
            best_tag_q    <= best_tag_d;
            hit_count_q   <= hit_count_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign metric_o      = metric_q;
    assign tag_o         = tag_q;
    assign hit_o         = hit_q;
    assign best_valid_o  = best_valid_q;
    assign best_metric_o = best_metric_q;
    assign best_tag_o    = best_tag_q;
    assign hit_count_o   = hit_count_q;
endmodule

// File: doc/metric_tracker.md
# metric_tracker

Pipelined, parametrised successor to the single-cycle leading-match metric block, built for the mischievous-hash search datapath. It accepts one candidate hash per cycle and computes its metric: the number of leading, MSB-first bits that match a target. It also keeps a running best metric together with the tag of the candidate that achieved it, flags threshold hits and counts them. Search engines stream their candidate digests into it, and the host reads the best result from it.

## Interface
- WIDTH, 160: hash width in bits.
- CHUNK, 32: stage-1 compare slice width. It must divide WIDTH.
- TAG_W, 64: candidate tag width, e.g. the nonce.
- CNT_W, 32: hit counter width.
- MW (localparam): $clog2(WIDTH+1)+1, the metric width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- target_i  in  WIDTH  target hash. It must be held stable while the pipeline is non-empty.
- threshold_i  in  MW  hit threshold. It is sampled in stage 2.
- in_valid_i  in  1  candidate present this cycle. Accepted unconditionally.
- hash_i  in  WIDTH  candidate hash
- tag_i  in  TAG_W  candidate tag
- clear_i  in  1  clears the best result and the hit counter
- out_valid_o  out  1  per-candidate result valid
- metric_o  out  MW  candidate metric
- tag_o  out  TAG_W  candidate tag
- hit_o  out  1  metric_o >= threshold_i. Qualified by out_valid_o.
- best_valid_o  out  1  at least one candidate scored since the last reset or clear
- best_metric_o  out  MW  highest metric seen
- best_tag_o  out  TAG_W  tag of the first candidate that reached best_metric_o
- hit_count_o  out  CNT_W  number of hits, saturating

## Operation
- diff = hash_i ^ target_i.
- Metric = WIDTH - 1 - (index of the highest set bit of diff). If diff == 0, the metric is WIDTH.
- Range: 0..WIDTH, zero-extended to MW.
- Stage 1 (registered):
  - For each of the WIDTH/CHUNK slices, MSB slice first, compute the leading-zero count of the slice diff (0..CHUNK) and an all-zero flag.
  - Register the counts and flags, plus valid and tag.
- Stage 2 (registered):
  - Find the first slice k (from the MSB side) that is not all-zero. Metric = k*CHUNK + count[k].
  - If every slice is all-zero, metric = WIDTH.
  - Register out_valid_o, metric_o, tag_o and hit_o.
- Best update:
  - Occurs on the same edge as stage 2, using the stage-2 metric that is being computed (not the registered one).
  - The update happens if the candidate is valid and either best_valid_o == 0 or metric > best_metric_o.
  - Strictly greater only: on a tie, the earlier tag is kept.
- Hit counter:
  - Increments on every valid candidate whose metric >= threshold_i.
  - Saturates at 2^CNT_W - 1.
- clear_i:
  - At the next edge: best_valid_o = 0, best_metric_o = 0, best_tag_o = 0, hit_count_o = 0.
  - clear_i has priority over a candidate completing stage 2 on the same edge. That candidate still appears on out_valid_o, metric_o, tag_o and hit_o, but it does not update the best result or the hit counter.
  - The pipeline is not flushed. Candidates in stage 1 are scored normally after the clear.
- Changing target_i with in-flight candidates gives undefined metrics for those candidates. This is a system-level rule, not a checked condition.

## Timing
- Throughput: 1 candidate per cycle, with no backpressure.
- Latency: a candidate accepted at edge N has its stage-1 registers loaded at edge N+1. Its out_valid_o, metric_o, tag_o and hit_o are visible after edge N+2. The best registers and the hit counter reflect it after edge N+2.
- out_valid_o is high for exactly one cycle per accepted candidate. Back-to-back candidates give back-to-back results, in order.
- Reset values (rst_i sampled high at an edge): every output is 0. The stage-1 valid is 0, which flushes the pipeline. Candidates in flight are dropped and produce no out_valid_o.
- rst_i has priority over clear_i and over in_valid_i.
- in_valid_i asserted in the same cycle as rst_i is ignored.

## Test plan
- Single-candidate latency: WIDTH=160, CHUNK=32. Drive hash = target ^ (1<<150) with tag 0x5 at cycle 0. Expect out_valid_o at cycle 2 with metric_o=9 and tag_o=0x5; best_valid_o=1, best_metric_o=9, best_tag_o=0x5 after the same edge.
- Boundary metrics:
  - hash == target gives 160.
  - diff bit 159 set gives 0.
  - diff bit 128 only gives 31.
  - diff bit 127 only gives 32 (first bit of the second chunk).
  - diff bits 0 and 1 only give 158.
- Best tracking and ties: stream metrics 5, 12, 12, 3, 40 with tags 1..5 back-to-back. Expect best after each result: 5/1, 12/2, 12/2, 12/2, 40/5.
- Hits and saturation: set threshold=10 and metrics 9, 10, 11. Expect hit_o = 0, 1, 1 and hit_count_o=2. With CNT_W=2, five hits leave hit_count_o at 3.
- Clear collision: a candidate with metric 50 is in stage 2 while clear_i=1. Expect metric_o=50 and out_valid_o=1, but best_valid_o=0 and hit_count_o=0 afterwards. A following candidate with metric 7 then sets best to 7.
- Reset mid-flight: drive candidates at cycles 0 and 1, then assert rst_i at cycle 1. Expect no out_valid_o, all outputs 0, and normal operation for a candidate at cycle 3.
